// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: clocked Gray-code sequencer driving the unclocked 16-bit sequential ALU datapath
module alu_seq_ctrl #(
  parameter int INIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic [1:0] opcode,
  input  logic       abort,
  output logic [4:0] cstate,
  output logic [1:0] op_out,
  output logic       busy,
  output logic       done,
  output logic       ld_ops
);
  localparam int CW = $clog2(INIT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(INIT_CYCLES - 1);
  localparam logic [4:0] S0  = 5'b00000;
  localparam logic [4:0] S1  = 5'b00001;
  localparam logic [4:0] S2  = 5'b00011;
  localparam logic [4:0] S3  = 5'b00010;
  localparam logic [4:0] S4  = 5'b00110;
  localparam logic [4:0] S5  = 5'b00111;
  localparam logic [4:0] S6  = 5'b00101;
  localparam logic [4:0] S7  = 5'b00100;
  localparam logic [4:0] S8  = 5'b01100;
  localparam logic [4:0] S9  = 5'b01101;
  localparam logic [4:0] S10 = 5'b01111;
  localparam logic [4:0] S11 = 5'b01110;
  localparam logic [4:0] S12 = 5'b01010;
  localparam logic [4:0] S13 = 5'b01011;
  localparam logic [4:0] S14 = 5'b01001;
  localparam logic [4:0] S15 = 5'b01000;
  localparam logic [4:0] S16 = 5'b11000;
  localparam logic [4:0] S20 = 5'b10001;
  localparam logic [4:0] S31 = 5'b10000;
  logic [4:0]    cstate_q, cstate_d, seq_nxt;
  logic [1:0]    op_q, op_d;
  logic          done_q, done_d, ld_q, ld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, in_op;
  // successor along the legal state graph; anything unrecognised falls back to S0
  always_comb begin
    seq_nxt = S0;
    case (cstate_q)
      S0:      seq_nxt = (cnt_q == LAST) ? S20 : S0;
      S20:     seq_nxt = start ? ((opcode[0] ^ opcode[1]) ? S1 : S31) : S20;
      S31:     seq_nxt = S20;
      S1:      seq_nxt = S2;
      S2:      seq_nxt = S3;
      S3:      seq_nxt = S4;
      S4:      seq_nxt = S5;
      S5:      seq_nxt = S6;
      S6:      seq_nxt = S7;
      S7:      seq_nxt = S8;
      S8:      seq_nxt = S9;
      S9:      seq_nxt = S10;
      S10:     seq_nxt = S11;
      S11:     seq_nxt = S12;
      S12:     seq_nxt = S13;
      S13:     seq_nxt = S14;
      S14:     seq_nxt = S15;
      S15:     seq_nxt = S16;
      S16:     seq_nxt = S20;
      default: seq_nxt = S0;
    endcase
  end
  // abort override, init counter, opcode capture and registered pulses
  always_comb begin
    accept   = (cstate_q == S20) && start;
    in_op    = (cstate_q != S0) && (cstate_q != S20);
    cstate_d = (abort && in_op) ? S0 : seq_nxt;
    cnt_d    = (cstate_q == S0 && cstate_d == S0) ? cnt_q + 1'b1 : '0;
    op_d     = accept ? opcode : op_q;
    ld_d     = accept;
    done_d   = (cstate_d == S20) && (cstate_q == S16 || cstate_q == S31);
  end
  // state and output flops; cstate leaves straight from these flops
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cstate_q <= S0;
      op_q     <= 2'b00;
      done_q   <= 1'b0;
      ld_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cstate_q <= cstate_d;
      op_q     <= op_d;
      done_q   <= done_d;
      ld_q     <= ld_d;
      cnt_q    <= cnt_d;
    end
  end
  assign cstate = cstate_q;
  assign op_out = op_q;
  assign busy   = cstate_q != S20;
  assign done   = done_q;
  assign ld_ops = ld_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed test of alu_seq_ctrl against a phase-level behavioural model
module tb_alu_seq_ctrl;
  localparam int INIT = 1;
  logic       clk = 0, nrst = 0, start = 0, abort = 0;
  logic [1:0] opcode = 0;
  logic [4:0] cstate;
  logic [1:0] op_out;
  logic       busy, done, ld_ops;
  int checks = 0, errors = 0;
  bit chk_en = 1, inject = 0;
  alu_seq_ctrl #(.INIT_CYCLES(INIT)) dut (
    .clk(clk), .nrst(nrst), .start(start), .opcode(opcode), .abort(abort),
    .cstate(cstate), .op_out(op_out), .busy(busy), .done(done), .ld_ops(ld_ops)
  );
  always #5 clk = ~clk;
  logic [4:0] gray [17] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111,
                            5'b00101, 5'b00100, 5'b01100, 5'b01101, 5'b01111, 5'b01110,
                            5'b01010, 5'b01011, 5'b01001, 5'b01000, 5'b11000};
  // model: 0 init, 1 idle, 2 mul/div stepping, 3 add/compare
  int mode = 0, step = 0, icnt = 0;
  logic [1:0] mop = 0;
  logic mdone = 0, mld = 0;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mode = 0; icnt = 0; mop = 0; mdone = 0; mld = 0;
    end else if (inject) begin
      mode = 0; icnt = 0; mdone = 0; mld = 0;
    end else begin
      mdone = 0; mld = 0;
      if (mode == 0) begin
        if (icnt == INIT - 1) begin mode = 1; icnt = 0; end else icnt++;
      end else if (mode == 1) begin
        if (start) begin
          mld = 1; mop = opcode; step = 1;
          mode = (opcode == 2'b01 || opcode == 2'b10) ? 2 : 3;
        end
      end else if (abort) begin
        mode = 0; icnt = 0;
      end else if (mode == 3 || step == 16) begin
        mode = 1; mdone = 1;
      end else step++;
    end
  end
  function automatic logic [4:0] exp_state();
    return mode == 0 ? 5'b00000 : mode == 1 ? 5'b10001 : mode == 3 ? 5'b10000 : gray[step];
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  logic [4:0] prev_cs = 0;
  // cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cstate", cstate, exp_state());
      chk("op_out", op_out, mop);
      chk("busy", busy, mode != 1);
      chk("done", done, mdone);
      chk("ld_ops", ld_ops, mld);
      if (mode == 2 && step > 1) chk("gray_step", $countones(cstate ^ prev_cs), 1);
    end
    prev_cs = cstate;
  end
  task automatic issue(input logic [1:0] op);
    @(negedge clk); start = 1; opcode = op;
    @(negedge clk); start = 0;
  endtask
  task automatic wait_state(input logic [4:0] s);
    int n = 0;
    while (cstate !== s && n < 40) begin @(negedge clk); n++; end
    if (cstate !== s) chk("wait_timeout", cstate, s);
  endtask
  int nd, nl;
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cstate", cstate, 5'b00000);
    chk("rst_busy", busy, 1);
    nrst = 1;
    @(negedge clk);
    chk("init_exit", cstate, 5'b10001);
    chk("idle_busy", busy, 0);
    issue(2'b01);
    chk("mul_ld", ld_ops, 1);
    chk("mul_op", op_out, 2'b01);
    for (int i = 1; i <= 16; i++) begin
      chk("mul_walk", cstate, gray[i]);
      if (i > 1) chk("mul_ld_low", ld_ops, 0);
      @(negedge clk);
    end
    chk("mul_end", cstate, 5'b10001);
    chk("mul_done", done, 1);
    issue(2'b11);
    chk("cmp_s31", cstate, 5'b10000);
    @(negedge clk);
    chk("cmp_end", cstate, 5'b10001);
    chk("cmp_done", done, 1);
    @(negedge clk);
    chk("cmp_done_pulse", done, 0);
    start = 1; opcode = 2'b00; nd = 0; nl = 0;
    repeat (8) begin @(negedge clk); nd += done; nl += ld_ops; end
    start = 0;
    chk("b2b_dones", nd, 4);
    chk("b2b_lds", nl, 4);
    @(negedge clk);
    issue(2'b10);
    wait_state(5'b01100);
    abort = 1;
    @(negedge clk); abort = 0;
    chk("abort_s0", cstate, 5'b00000);
    chk("abort_op", op_out, 2'b10);
    nd = done;
    @(negedge clk);
    nd += done;
    chk("abort_idle", cstate, 5'b10001);
    chk("abort_nodone", nd, 0);
    issue(2'b00);
    chk("post_abort_accept", cstate, 5'b10000);
    @(negedge clk);
    issue(2'b01);
    wait_state(5'b01010);
    #3 nrst = 0;
    #1 chk("async_cstate", cstate, 5'b00000);
    chk("async_op", op_out, 2'b00);
    chk("async_done", done, 0);
    @(negedge clk); nrst = 1;
    @(negedge clk);
    chk("rst_recover", cstate, 5'b10001);
    @(negedge clk); chk_en = 0;
    #1 force dut.cstate_q = 5'b11111;
    #1 release dut.cstate_q;
    inject = 1;
    @(negedge clk);
    chk("illegal_s0", cstate, 5'b00000);
    chk("illegal_nodone", done, 0);
    inject = 0;
    @(negedge clk);
    chk("illegal_recover", cstate, 5'b10001);
    chk("illegal_nodone2", done, 0);
    chk_en = 1;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
